// File: rtl/sm_mult_datapath.sv
// sm_mult_datapath: register/arithmetic half of the shift-add sequential
// multiplier. Holds the multiplicand (MD), multiplier (MR), the 2*WIDTH-bit
// running sum (RS) and the carry flop between an add and the following shift.
// All sequencing comes from the external controller through the strobes.
//
// Optional build macro SMDP_SHIFT_CHECK_EN adds a shift counter (shcnt) and a
// sticky protocol error flag (err) that catches controller sequencing faults.
module sm_mult_datapath #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   mdin,
  input  logic [WIDTH-1:0]   mrin,
  input  logic               mdld,
  input  logic               mrld,
  input  logic               rsload,
  input  logic               rsclear,
  input  logic               rsshr,
`ifdef SMDP_SHIFT_CHECK_EN
  output logic [$clog2(WIDTH+1):0] shcnt,
  output logic               err,
`endif
  output logic [WIDTH-1:0]   mr,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   md_q;
  logic [WIDTH-1:0]   mr_q;
  logic [2*WIDTH-1:0] rs_q;
  logic               carry_q;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] rs_d;
  logic               carry_d;

  // Adder always sees the MD held before the edge, so a same-cycle mdld
  // never feeds the add.
  assign sum = {1'b0, rs_q[2*WIDTH-1:WIDTH]} + {1'b0, md_q};

  // Next running sum and carry: clear beats add, fused add-shift drops the
  // adder carry straight into the MSB, plain shift drains the held carry.
  always_comb begin
    rs_d    = rs_q;
    carry_d = carry_q;
    if (rsclear) begin
      rs_d    = '0;
      carry_d = 1'b0;
    end else if (rsload && !rsshr) begin
      rs_d    = {sum[WIDTH-1:0], rs_q[WIDTH-1:0]};
      carry_d = sum[WIDTH];
    end else if (rsload && rsshr) begin
      rs_d    = {sum, rs_q[WIDTH-1:1]};
      carry_d = 1'b0;
    end else if (rsshr) begin
      rs_d    = {carry_q, rs_q[2*WIDTH-1:1]};
      carry_d = 1'b0;
    end
  end

  // Operand and running-sum registers; reset wins over every strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_q    <= '0;
      mr_q    <= '0;
      rs_q    <= '0;
      carry_q <= 1'b0;
    end else begin
      if (mdld) md_q <= mdin;
      if (mrld) mr_q <= mrin;
      rs_q    <= rs_d;
      carry_q <= carry_d;
    end
  end

  assign mr      = mr_q;
  assign product = rs_q;

`ifdef SMDP_SHIFT_CHECK_EN
  localparam int CW = $clog2(WIDTH+1) + 1;
  localparam logic [CW-1:0] SH_FULL = CW'(WIDTH);

  logic [CW-1:0] shcnt_q;
  logic          err_q;
  logic          over_shift;
  logic          lost_carry;
  logic          load_mid_op;

  // Protocol fault detectors evaluated against the state before the edge.
  assign over_shift  = rsshr && (shcnt_q == SH_FULL);
  assign lost_carry  = rsload && !rsshr && carry_q;
  assign load_mid_op = (mdld || mrld) && (shcnt_q != '0) && (shcnt_q < SH_FULL);

  // Shift counter saturates instead of wrapping; err is sticky until a clear.
  always_ff @(posedge clk) begin
    if (rst || rsclear) begin
      shcnt_q <= '0;
      err_q   <= 1'b0;
    end else begin
      if (rsshr && (shcnt_q != '1)) shcnt_q <= shcnt_q + 1'b1;
      if (over_shift || lost_carry || load_mid_op) err_q <= 1'b1;
    end
  end

  assign shcnt = shcnt_q;
  assign err   = err_q;
`endif

endmodule
